// File: rtl/debounce_multi_if.sv
// Signal bundle between raw buttons and the debouncer: raw inputs in,
// debounced levels, edge pulses, sample strobe and long-press pulses out.
interface debounce_multi_if #(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] key;
  logic [N_CH-1:0] key_rise;
  logic [N_CH-1:0] key_fall;
  logic [N_CH-1:0] long_press;
  logic            tick;

  modport master (
    output btn_in,
    input  key, key_rise, key_fall, long_press, tick
  );

  modport slave (
    input  btn_in,
    output key, key_rise, key_fall, long_press, tick
  );
endinterface

// File: rtl/debounce_multi.sv
// N-channel button debouncer: 2-flop synchronisers, shared tick prescaler, per-channel
// stability counters and rise/fall pulses. Define DEBOUNCE_LONG_PRESS_EN for long_press.
module debounce_multi #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CLK_DIV    = 50000,
  parameter int unsigned STABLE_CNT = 30,
  parameter int unsigned CNT_W      = 5,
  parameter int unsigned LONG_TICKS = 1000
) (
  input logic             clk,
  input logic             rst,
  debounce_multi_if.slave bus
);

  localparam int unsigned DivW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 2 || STABLE_CNT < 1 || (64'd1 << CNT_W) <= 64'(STABLE_CNT) ||
      LONG_TICKS < 1) begin : g_param_check
    $error("debounce_multi: illegal parameter combination");
  end

  logic [DivW-1:0]  div_cnt_q, div_cnt_d;
  logic             tick;
  logic [N_CH-1:0]  sync0_q, sync1_q;
  logic [N_CH-1:0]  prev_q, prev_d;
  logic [N_CH-1:0]  key_q, key_d;
  logic [N_CH-1:0]  rise_q, rise_d;
  logic [N_CH-1:0]  fall_q, fall_d;
  logic [CNT_W-1:0] stab_q [N_CH];
  logic [CNT_W-1:0] stab_d [N_CH];

  assign tick = (div_cnt_q == DivW'(CLK_DIV - 1));

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + DivW'(1);
  end

  always_comb begin
    prev_d = prev_q;
    key_d  = key_q;
    rise_d = '0;
    fall_d = '0;
    stab_d = stab_q;
    if (tick) begin
      prev_d = sync1_q;
      for (int i = 0; i < N_CH; i++) begin
        if (sync1_q[i] != prev_q[i]) begin
          stab_d[i] = '0;
        end else begin
          if (stab_q[i] < CNT_W'(STABLE_CNT)) stab_d[i] = stab_q[i] + CNT_W'(1);
          // Crossing into STABLE_CNT commits the level; pulses only on a real change.
          if (stab_q[i] == CNT_W'(STABLE_CNT - 1)) begin
            key_d[i]  = sync1_q[i];
            rise_d[i] = sync1_q[i] & ~key_q[i];
            fall_d[i] = ~sync1_q[i] & key_q[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      sync0_q   <= '0;
      sync1_q   <= '0;
      prev_q    <= '0;
      key_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      for (int i = 0; i < N_CH; i++) stab_q[i] <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sync0_q   <= bus.btn_in;
      sync1_q   <= sync0_q;
      prev_q    <= prev_d;
      key_q     <= key_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      stab_q    <= stab_d;
    end
  end

  assign bus.key      = key_q;
  assign bus.key_rise = rise_q;
  assign bus.key_fall = fall_q;
  assign bus.tick     = tick;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HoldW = $clog2(LONG_TICKS + 1);

  logic [HoldW-1:0] hold_q [N_CH];
  logic [HoldW-1:0] hold_d [N_CH];
  logic [N_CH-1:0]  lp_q, lp_d;

  // Saturating at LONG_TICKS gives one pulse per press; release re-arms.
  always_comb begin
    hold_d = hold_q;
    lp_d   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!key_q[i]) begin
        hold_d[i] = '0;
      end else if (tick && hold_q[i] < HoldW'(LONG_TICKS)) begin
        hold_d[i] = hold_q[i] + HoldW'(1);
        if (hold_q[i] == HoldW'(LONG_TICKS - 1)) lp_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lp_q <= '0;
      for (int i = 0; i < N_CH; i++) hold_q[i] <= '0;
    end else begin
      lp_q   <= lp_d;
      hold_q <= hold_d;
    end
  end

  assign bus.long_press = lp_q;
`else
  assign bus.long_press = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with CLK_DIV=4, STABLE_CNT=3, N_CH=4, LONG_TICKS=5.
module tb_debounce_multi;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  debounce_multi_if #(.N_CH(4)) bus ();

  debounce_multi #(
    .N_CH(4), .CLK_DIV(4), .STABLE_CNT(3), .CNT_W(2), .LONG_TICKS(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the edge that makes tick visible; next edge is a sample edge.
  task automatic wait_tick();
    for (int n = 0; n < 20; n++) begin
      step();
      if (bus.tick) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_tick: tick not seen within 20 clk");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.btn_in = '0;
    repeat (3) step();
    checks++;
    if ({bus.key, bus.key_rise, bus.key_fall, bus.long_press, bus.tick} !== 17'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0",
               {bus.key, bus.key_rise, bus.key_fall, bus.long_press, bus.tick});
    end
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      checks++;
      if (bus.tick !== (k % 4 == 3)) begin
        errors++;
        $display("FAIL idle_tick k=%0d: got %b want %b", k, bus.tick, (k % 4 == 3));
      end
      checks++;
      if ({bus.key, bus.key_rise, bus.key_fall, bus.long_press} !== 16'b0) begin
        errors++;
        $display("FAIL idle_outputs k=%0d: got %h want 0", k,
                 {bus.key, bus.key_rise, bus.key_fall, bus.long_press});
      end
    end
  endtask

  task automatic test_rise();
    logic [3:0] ek, er;
    wait_tick();
    bus.btn_in[0] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      ek = (k >= 17) ? 4'b0001 : 4'b0000;
      er = (k == 17) ? 4'b0001 : 4'b0000;
      checks++;
      if (bus.key !== ek || bus.key_rise !== er || bus.key_fall !== 4'b0) begin
        errors++;
        $display("FAIL rise k=%0d: key=%b rise=%b fall=%b want key=%b rise=%b fall=0000",
                 k, bus.key, bus.key_rise, bus.key_fall, ek, er);
      end
    end
  endtask

  task automatic test_bounce();
    wait_tick();
    bus.btn_in[1] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 8) bus.btn_in[1] = 1'b0;
      checks++;
      if (bus.key !== 4'b0001 || bus.key_rise !== 4'b0 || bus.key_fall !== 4'b0) begin
        errors++;
        $display("FAIL bounce k=%0d: key=%b rise=%b fall=%b want key=0001 rise=0 fall=0",
                 k, bus.key, bus.key_rise, bus.key_fall);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ek, ep;
    wait_tick();
    bus.btn_in = 4'b1101;
    for (int k = 1; k <= 18; k++) begin
      step();
      ek = (k >= 17) ? 4'b1101 : 4'b0001;
      ep = (k == 17) ? 4'b1100 : 4'b0000;
      checks++;
      if (bus.key !== ek || bus.key_rise !== ep || bus.key_fall !== 4'b0) begin
        errors++;
        $display("FAIL simul_rise k=%0d: key=%b rise=%b fall=%b want key=%b rise=%b",
                 k, bus.key, bus.key_rise, bus.key_fall, ek, ep);
      end
    end
    wait_tick();
    bus.btn_in = 4'b0001;
    for (int k = 1; k <= 18; k++) begin
      step();
      ek = (k >= 17) ? 4'b0001 : 4'b1101;
      ep = (k == 17) ? 4'b1100 : 4'b0000;
      checks++;
      if (bus.key !== ek || bus.key_fall !== ep || bus.key_rise !== 4'b0) begin
        errors++;
        $display("FAIL simul_fall k=%0d: key=%b fall=%b rise=%b want key=%b fall=%b",
                 k, bus.key, bus.key_fall, bus.key_rise, ek, ep);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ek, er;
    bus.btn_in[0] = 1'b0;
    repeat (5) step();
    bus.btn_in[0] = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    step();
    checks++;
    if ({bus.key, bus.key_rise, bus.key_fall, bus.long_press, bus.tick} !== 17'b0) begin
      errors++;
      $display("FAIL mid_reset: got %b want 0",
               {bus.key, bus.key_rise, bus.key_fall, bus.long_press, bus.tick});
    end
    rst = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step();
      ek = (k >= 16) ? 4'b0001 : 4'b0000;
      er = (k == 16) ? 4'b0001 : 4'b0000;
      checks++;
      if (bus.key !== ek || bus.key_rise !== er || bus.tick !== (k % 4 == 3)) begin
        errors++;
        $display("FAIL restart k=%0d: key=%b rise=%b tick=%b want key=%b rise=%b tick=%b",
                 k, bus.key, bus.key_rise, bus.tick, ek, er, (k % 4 == 3));
      end
    end
  endtask

`ifdef DEBOUNCE_LONG_PRESS_EN
  task automatic test_long_press();
    logic [3:0] ep;
    for (int rep = 0; rep < 2; rep++) begin
      wait_tick();
      bus.btn_in[3] = 1'b1;
      for (int k = 1; k <= 60; k++) begin
        step();
        ep = (k == 37) ? 4'b1000 : 4'b0000;
        checks++;
        if (bus.long_press !== ep) begin
          errors++;
          $display("FAIL long_press rep=%0d k=%0d: got %b want %b", rep, k,
                   bus.long_press, ep);
        end
      end
      bus.btn_in[3] = 1'b0;
      repeat (24) step();
    end
  endtask
`else
  task automatic test_long_press();
    wait_tick();
    bus.btn_in[3] = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      checks++;
      if (bus.long_press !== 4'b0) begin
        errors++;
        $display("FAIL long_press_off k=%0d: got %b want 0000", k, bus.long_press);
      end
    end
    bus.btn_in[3] = 1'b0;
    repeat (24) step();
  endtask
`endif

  initial begin
    test_reset();
    test_rise();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    test_long_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
